// File: rtl/tick_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_pkg
// Description : Shared types, default parameters and the quiet-condition
//               helper for the timestep tick sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

  // Default parameter values
  localparam int C_NUM_CH_DEF   = 4;
  localparam int C_QUIET_W_DEF  = 3;
  localparam int C_PERIOD_W_DEF = 32;
  localparam int C_TS_W_DEF     = 16;

  // Sequencer states; encoding 3 is unused and recovers to idle
  typedef enum logic [1:0] {
    TS_IDLE     = 2'd0,
    TS_DRAIN    = 2'd1,
    TS_PERIODIC = 2'd2
  } ts_state_e;

  // Grid is quiet when nothing is queued at the input, the grid FSM is idle
  // and every router channel is empty (caller supplies the AND of ch_empty)
  function automatic logic quiet_f(input logic input_empty,
                                   input logic grid_idle,
                                   input logic all_ch_empty);
    return input_empty & grid_idle & all_ch_empty;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_sequencer_if
// Description : Config, status and tick signals of the tick sequencer.
//               master = controller/environment side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_sequencer_if
  import tick_pkg::*;
#(
  parameter int NUM_CH   = C_NUM_CH_DEF,
  parameter int QUIET_W  = C_QUIET_W_DEF,
  parameter int PERIOD_W = C_PERIOD_W_DEF,
  parameter int TS_W     = C_TS_W_DEF
) ();

  logic [QUIET_W-1:0]  cfg_quiet;
  logic [PERIOD_W-1:0] cfg_period;
  logic [TS_W-1:0]     cfg_max_ts;
  logic                input_empty;
  logic                grid_idle;
  logic [NUM_CH-1:0]   ch_empty;
  logic                phase_done;
  logic                complete;
  logic                tick;
  logic [TS_W-1:0]     tick_cnt;
  logic                done;
  logic [1:0]          state_o;

  modport master (
    output cfg_quiet, cfg_period, cfg_max_ts, input_empty, grid_idle,
           ch_empty, phase_done, complete,
    input  tick, tick_cnt, done, state_o
  );

  modport slave (
    input  cfg_quiet, cfg_period, cfg_max_ts, input_empty, grid_idle,
           ch_empty, phase_done, complete,
    output tick, tick_cnt, done, state_o
  );

endinterface
`default_nettype wire

// File: rtl/tick_interval_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tick_interval_cnt
// Description : Wrapping up-counter with clear/enable and an equal-to-target
//               flag. Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_interval_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and wrap naturally
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == target);

endmodule
`default_nettype wire

// File: rtl/tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tick_sequencer
// Description : Timestep tick generator for the SNN grid. Ticks after a
//               quiet window while draining, then at a fixed period, with an
//               optional timestep limit that returns the sequencer to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sequencer
  import tick_pkg::*;
#(
  parameter int NUM_CH   = C_NUM_CH_DEF,
  parameter int QUIET_W  = C_QUIET_W_DEF,
  parameter int PERIOD_W = C_PERIOD_W_DEF,
  parameter int TS_W     = C_TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  tick_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = TS_IDLE;
  localparam logic [1:0] ST_DRAIN    = TS_DRAIN;
  localparam logic [1:0] ST_PERIODIC = TS_PERIODIC;

  logic [1:0]      state_q, state_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic [TS_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TS_W-1:0] tick_cnt_inc;

  logic quiet;
  logic q_clr, q_en, q_hit;
  logic p_clr, p_en, p_hit;
  logic issue;

  assign quiet = quiet_f(bus.input_empty, bus.grid_idle, &bus.ch_empty);

  // Saturating successor of the timestep count
  assign tick_cnt_inc = (&tick_cnt_q) ? tick_cnt_q : tick_cnt_q + 1'b1;

  tick_interval_cnt #(.W(QUIET_W)) u_quiet_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (q_clr),
    .en     (q_en),
    .target (bus.cfg_quiet),
    .hit    (q_hit)
  );

  tick_interval_cnt #(.W(PERIOD_W)) u_period_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (p_clr),
    .en     (p_en),
    .target (bus.cfg_period),
    .hit    (p_hit)
  );

  // Next-state, counter control, tick decision and timestep limit
  always_comb begin
    state_d    = state_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    q_clr      = 1'b0;
    q_en       = 1'b0;
    p_clr      = 1'b0;
    p_en       = 1'b0;
    issue      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        q_clr = 1'b1;
        p_clr = 1'b1;
        if (!bus.input_empty) begin
          state_d    = ST_DRAIN;
          tick_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // A busy cycle restarts the quiet window from zero
        if (quiet) begin
          if (q_hit) begin
            issue = 1'b1;
            q_clr = 1'b1;
          end else begin
            q_en = 1'b1;
          end
        end else begin
          q_clr = 1'b1;
        end
        if (bus.phase_done) begin
          state_d = ST_PERIODIC;
          p_clr   = 1'b1;
        end
      end
      ST_PERIODIC: begin
        // complete aborts the run and swallows any tick due this cycle
        if (bus.complete) begin
          state_d = ST_IDLE;
        end else if (p_hit) begin
          issue = 1'b1;
          p_clr = 1'b1;
        end else begin
          p_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Limit check overrides any phase transition decided above
    if (issue) begin
      tick_d     = 1'b1;
      tick_cnt_d = tick_cnt_inc;
      if ((bus.cfg_max_ts != '0) && (tick_cnt_inc == bus.cfg_max_ts)) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.done     = done_q;
  assign bus.tick_cnt = tick_cnt_q;
  assign bus.state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_sequencer
// Description : Directed self-checking bench for tick_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  tick_sequencer_if #(.NUM_CH(4), .QUIET_W(3), .PERIOD_W(32), .TS_W(16)) bus ();

  tick_sequencer #(.NUM_CH(4), .QUIET_W(3), .PERIOD_W(32), .TS_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic t, input logic d,
                            input logic [15:0] cnt, input logic [1:0] st);
    check({tag, ".tick"}, 32'(bus.tick), 32'(t));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".tick_cnt"}, 32'(bus.tick_cnt), 32'(cnt));
    check({tag, ".state"}, 32'(bus.state_o), 32'(st));
  endtask

  initial begin
    int steps;
    int stray;
    n_checks = 0;
    n_errors = 0;

    rst             = 1'b1;
    bus.cfg_quiet   = 3'd7;
    bus.cfg_period  = 32'd0;
    bus.cfg_max_ts  = 16'd0;
    bus.input_empty = 1'b1;
    bus.grid_idle   = 1'b1;
    bus.ch_empty    = 4'hF;
    bus.phase_done  = 1'b0;
    bus.complete    = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 16'd0, 2'd0);
    rst = 1'b0;

    // Drain with cfg_quiet=7: ticks 8 and 16 cycles after first quiet cycle
    bus.input_empty = 1'b0;
    step();
    check_outs("drain_entry", 1'b0, 1'b0, 16'd0, 2'd1);
    bus.input_empty = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("drain_tick_k%0d", k), 32'(bus.tick), 32'((k == 8) || (k == 16)));
    end
    check_outs("drain_end", 1'b0, 1'b0, 16'd2, 2'd1);

    // Busy cycle restarts the window (cfg_quiet=3)
    bus.grid_idle = 1'b0;
    step();
    check("busy_flush.tick", 32'(bus.tick), 32'd0);
    bus.grid_idle = 1'b1;
    bus.cfg_quiet = 3'd3;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("pre_busy_k%0d", k), 32'(bus.tick), 32'd0);
    end
    bus.ch_empty = 4'b1011;
    step();
    check("busy_cycle.tick", 32'(bus.tick), 32'd0);
    bus.ch_empty = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post_busy_k%0d", k), 32'(bus.tick), 32'(k == 4));
    end
    check("post_busy.tick_cnt", 32'(bus.tick_cnt), 32'd3);

    // cfg_quiet=0: tick on every quiet cycle, including the phase_done cycle
    bus.cfg_quiet = 3'd0;
    step();
    check_outs("q0_a", 1'b1, 1'b0, 16'd4, 2'd1);
    step();
    check_outs("q0_b", 1'b1, 1'b0, 16'd5, 2'd1);
    bus.phase_done = 1'b1;
    step();
    check_outs("q0_phase_done", 1'b1, 1'b0, 16'd6, 2'd2);
    bus.phase_done = 1'b0;

    // cfg_period=0: tick every cycle
    for (int k = 1; k <= 3; k++) begin
      step();
      check_outs($sformatf("p0_k%0d", k), 1'b1, 1'b0, 16'(6 + k), 2'd2);
    end

    // cfg_period=1004: ticks every 1005 cycles
    bus.cfg_period = 32'd1004;
    for (int r = 0; r < 2; r++) begin
      steps = 0;
      stray = 0;
      do begin
        step();
        steps++;
      end while (!bus.tick && steps < 1100);
      check($sformatf("period_spacing_%0d", r), 32'(steps), 32'd1005);
    end
    check("period.tick_cnt", 32'(bus.tick_cnt), 32'd11);

    // complete on the p==1004 cycle suppresses the tick and returns to idle
    stray = 0;
    for (int k = 0; k < 1004; k++) begin
      step();
      if (bus.tick) stray++;
    end
    check("pre_complete.stray_ticks", 32'(stray), 32'd0);
    bus.complete = 1'b1;
    step();
    check_outs("complete", 1'b0, 1'b0, 16'd11, 2'd0);
    bus.complete = 1'b0;

    // Reset in PERIODIC with p=500
    bus.input_empty = 1'b0;
    step();
    check_outs("rerun_entry", 1'b0, 1'b0, 16'd0, 2'd1);
    bus.input_empty = 1'b1;
    step();
    step();
    bus.phase_done = 1'b1;
    step();
    check_outs("rerun_periodic", 1'b1, 1'b0, 16'd3, 2'd2);
    bus.phase_done = 1'b0;
    for (int k = 0; k < 500; k++) step();
    check_outs("p500", 1'b0, 1'b0, 16'd3, 2'd2);
    rst = 1'b1;
    step();
    check_outs("midrun_reset", 1'b0, 1'b0, 16'd0, 2'd0);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.tick || bus.done || bus.state_o != 2'd0) stray++;
    end
    check("post_reset.quiet", 32'(stray), 32'd0);

    // Timestep limit: cfg_max_ts=3, cfg_quiet=0
    bus.cfg_max_ts  = 16'd3;
    bus.input_empty = 1'b0;
    step();
    check_outs("lim_entry", 1'b0, 1'b0, 16'd0, 2'd1);
    bus.input_empty = 1'b1;
    step();
    check_outs("lim_t1", 1'b1, 1'b0, 16'd1, 2'd1);
    step();
    check_outs("lim_t2", 1'b1, 1'b0, 16'd2, 2'd1);
    step();
    check_outs("lim_t3", 1'b1, 1'b1, 16'd3, 2'd0);
    step();
    check_outs("lim_after1", 1'b0, 1'b0, 16'd3, 2'd0);
    step();
    check_outs("lim_after2", 1'b0, 1'b0, 16'd3, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_sequencer.md
# tick_sequencer

Parametrised timestep-tick generator for the SNN grid. It replaces the fixed-width tick generator with a configurable design: N forward-buffer empty flags, a runtime quiet window, a runtime periodic interval and an optional timestep limit. It issues the one-cycle `tick` that advances every neuron core to the next timestep. It sits beside the grid controller and watches the input buffer, the grid FSM and the router buffers.

## Interface
- `NUM_CH`, 4: number of forward/north/local buffer-empty flags monitored.
- `QUIET_W`, 3: width of the quiet-window counter and of `cfg_quiet`.
- `PERIOD_W`, 32: width of the periodic counter and of `cfg_period`.
- `TS_W`, 16: width of the timestep counter and of `cfg_max_ts`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_quiet`  in  QUIET_W  quiet cycles required before a drain-phase tick; compared against the quiet counter.
- `cfg_period`  in  PERIOD_W  periodic-phase interval; compared against the period counter.
- `cfg_max_ts`  in  TS_W  timestep limit; 0 means unlimited.
- `input_empty`  in  1  input spike buffer empty.
- `grid_idle`  in  1  grid FSM in its idle state.
- `ch_empty`  in  NUM_CH  per-channel router buffer empty.
- `phase_done`  in  1  controller has entered the output/periodic phase.
- `complete`  in  1  run finished; return to idle.
- `tick`  out  1  registered one-cycle timestep pulse.
- `tick_cnt`  out  TS_W  ticks issued since the run started.
- `done`  out  1  registered one-cycle pulse when `cfg_max_ts` is reached.
- `state_o`  out  2  current FSM state.

## Operation
States: IDLE=0, DRAIN=1, PERIODIC=2. Encoding 3 is unused and recovers to IDLE.

Definitions:
- `quiet = input_empty & grid_idle & (&ch_empty)`.
- `q` is the quiet counter (QUIET_W bits).
- `p` is the period counter (PERIOD_W bits).

IDLE:
- `q` and `p` are cleared.
- `!input_empty` moves to DRAIN and clears `tick_cnt`.

DRAIN:
- If `quiet` and `q == cfg_quiet`: issue a tick and clear `q`.
- If `quiet` and `q != cfg_quiet`: increment `q`.
- If `!quiet`: clear `q`. Any busy cycle restarts the window; there is no down-count and no underflow.
- `phase_done` moves to PERIODIC and clears `p`. A tick decided in the same cycle is still issued.
- `cfg_quiet == 0` gives a tick on every quiet cycle.

PERIODIC:
- `complete` has priority: go to IDLE and suppress any tick that cycle.
- Otherwise, if `p == cfg_period`: issue a tick and clear `p`. Otherwise increment `p`.
- `cfg_period == 0` gives a tick every cycle.

Issuing a tick:
- `tick_cnt` increments and saturates at all-ones.
- If `cfg_max_ts != 0` and the incremented value equals `cfg_max_ts`, `done` pulses with the tick and the FSM goes to IDLE. This limit check has priority over `phase_done`.

Config inputs are sampled every cycle. Changing them mid-run takes effect on the next comparison. If `q` or `p` already exceeds a lowered target, the counter runs until it wraps.

## Timing
- Reset values: `tick=0`, `done=0`, `tick_cnt=0`, `state_o=IDLE`; `q` and `p` are 0.
- Reset mid-run aborts immediately. No tick or done pulse is issued in the cycle after reset.
- `tick` and `done` are registered. The qualifying condition in cycle n gives the pulse in cycle n+1, one cycle wide.
- `tick_cnt` updates in the same edge as `tick` rises.
- DRAIN tick spacing:
  - Continuous quiet: `cfg_quiet+1` cycles between ticks.
  - First tick after entering DRAIN: `cfg_quiet+1` quiet cycles after entry.
- PERIODIC tick spacing: `cfg_period+1` cycles between ticks.
- State transitions take effect at the next edge. `state_o` is the registered state.
- `complete` in DRAIN is ignored. Only `phase_done` leaves DRAIN, apart from reset or the timestep limit.

## Structure
- Package `tick_pkg`:
  - State enum (`TS_IDLE`, `TS_DRAIN`, `TS_PERIODIC`).
  - Default parameter constants.
  - The `quiet` reduction as a function.
- One sub-module, `tick_interval_cnt`: a parametrised width counter with clear, enable and compare-equal-to-target. It is instantiated twice, for `q` and `p`.
- The FSM, `tick_cnt` saturation and the limit logic live in the top module.

## Test plan
- Drain-phase ticks: `cfg_quiet=7`, `cfg_max_ts=0`. Make `input_empty` low for one cycle, then hold `quiet` high for 20 cycles. Required: ticks 8 and 16 cycles after the first quiet cycle (+1 register latency), `tick_cnt=2`.
- Busy cycle restarts the window: `cfg_quiet=3`. Quiet for 3 cycles, drop `ch_empty[2]` for one cycle, then quiet again. Required: no tick until 4 consecutive quiet cycles have elapsed after the busy cycle.
- Periodic phase: `cfg_period=1004` (0x3ec). Pulse `phase_done` in DRAIN. Required: ticks every 1005 cycles. `complete` on the same cycle as `p==1004` gives no tick and `state_o=0` next cycle.
- Timestep limit: `cfg_max_ts=3`, `cfg_quiet=0`, continuous quiet. Required: exactly 3 ticks, `done` coincident with the 3rd tick, then IDLE with `tick_cnt` held at 3.
- Reset mid-run: assert `rst` mid-PERIODIC with `p=500`. Required: next cycle all outputs are 0, `state_o=0`, and no tick occurs.
- Zero intervals: `cfg_period=0` gives a tick every cycle. `cfg_quiet=0` gives a tick on every quiet cycle. A tick and `phase_done` in the same DRAIN cycle still produce the tick.
